// File: rtl/ni_pkg.sv
// Shared constants for the PE-side network-interface injector:
// flit type codes, header field offsets and the injector FSM encoding.
package ni_pkg;

  localparam logic [1:0] FT_HEAD = 2'b11;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b01;
  localparam logic [1:0] FT_IDLE = 2'b00;

  // LSB positions of the header fields (40-bit flit, 3-bit coords, 4-bit len)
  localparam int HDR_DST_X_LSB = 35;
  localparam int HDR_DST_Y_LSB = 32;
  localparam int HDR_DST_Z_LSB = 29;
  localparam int HDR_SRC_X_LSB = 26;
  localparam int HDR_SRC_Y_LSB = 23;
  localparam int HDR_SRC_Z_LSB = 20;
  localparam int HDR_LEN_LSB   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HEAD  = 2'd1,
    S_BODY  = 2'd2,
    S_TAILZ = 2'd3
  } ni_state_e;

endpackage

// File: rtl/ni_payload_fifo.sv
// Payload buffer between the PE data port and the flit serialiser.
// Pointers carry one extra wrap bit; full/empty are registered so the
// link-side request never depends on same-cycle push/pop activity.
module ni_payload_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Next pointer values and the flags they imply
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Pointer and flag registers; reset flushes the buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array, no reset needed since empty_q masks stale entries
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/ni_inject.sv
// PE-side injector: turns a packet descriptor plus buffered payload words
// into head/body/tail flits on the router's req/grant local port.
//
// state | meaning
// IDLE  | waiting for a descriptor, pkt_ready high
// HEAD  | presenting the header flit
// BODY  | presenting payload flits from the FIFO, last one typed tail
// TAILZ | zero-length packet: presenting an empty tail flit
module ni_inject
  import ni_pkg::*;
#(
  parameter int FW      = 40,
  parameter int COORD_W = 3,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 8,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0,
  parameter int MY_Z    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [COORD_W-1:0] pkt_dst_x,
  input  logic [COORD_W-1:0] pkt_dst_y,
  input  logic [COORD_W-1:0] pkt_dst_z,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic               dat_valid,
  output logic               dat_ready,
  input  logic [FW-3:0]      dat_in,
  output logic [FW-1:0]      flit_out,
  output logic               req_out,
  input  logic               grnt_in,
  output logic               busy,
  output logic               pkt_sent
);

  ni_state_e          state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [COORD_W-1:0] dst_x_q, dst_y_q, dst_z_q;
  logic [LEN_W-1:0]   len_q;
  logic               sent_q;

  logic               fifo_full, fifo_empty;
  logic [FW-3:0]      fifo_rdata;
  logic               push, pop, xfer;
  logic               req_c;
  logic [FW-1:0]      flit_c;
  logic [FW-1:0]      header;

  assign dat_ready = !rst && !fifo_full;
  assign push      = dat_valid && dat_ready;
  assign xfer      = req_out && grnt_in;
  assign pop       = (state_q == S_BODY) && xfer;

  ni_payload_fifo #(
    .W     (FW-2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (dat_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Header flit built from the latched descriptor and this node's address
  always_comb begin
    header                                 = '0;
    header[FW-1:FW-2]                      = FT_HEAD;
    header[HDR_DST_X_LSB +: COORD_W]       = dst_x_q;
    header[HDR_DST_Y_LSB +: COORD_W]       = dst_y_q;
    header[HDR_DST_Z_LSB +: COORD_W]       = dst_z_q;
    header[HDR_SRC_X_LSB +: COORD_W]       = COORD_W'(MY_X);
    header[HDR_SRC_Y_LSB +: COORD_W]       = COORD_W'(MY_Y);
    header[HDR_SRC_Z_LSB +: COORD_W]       = COORD_W'(MY_Z);
    header[HDR_LEN_LSB +: LEN_W]           = len_q;
  end

  // Injection FSM with remaining-flit counter and the pkt_sent pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
      dst_z_q <= '0;
      len_q   <= '0;
      sent_q  <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pkt_valid) begin
            dst_x_q <= pkt_dst_x;
            dst_y_q <= pkt_dst_y;
            dst_z_q <= pkt_dst_z;
            len_q   <= pkt_len;
            rem_q   <= pkt_len;
            state_q <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (grnt_in) state_q <= (rem_q != '0) ? S_BODY : S_TAILZ;
        end
        S_BODY: begin
          if (pop) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q <= S_IDLE;
              sent_q  <= 1'b1;
            end
          end
        end
        S_TAILZ: begin
          if (grnt_in) begin
            state_q <= S_IDLE;
            sent_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Link output mux; the flit is zero whenever no request is raised
  always_comb begin
    req_c  = 1'b0;
    flit_c = {FT_IDLE, {(FW-2){1'b0}}};
    case (state_q)
      S_HEAD: begin
        req_c  = 1'b1;
        flit_c = header;
      end
      S_BODY: begin
        if (!fifo_empty) begin
          req_c  = 1'b1;
          flit_c = {(rem_q == LEN_W'(1)) ? FT_TAIL : FT_BODY, fifo_rdata};
        end
      end
      S_TAILZ: begin
        req_c  = 1'b1;
        flit_c = {FT_TAIL, {(FW-2){1'b0}}};
      end
      default: ;
    endcase
  end

  assign req_out   = req_c && !rst;
  assign flit_out  = rst ? '0 : flit_c;
  assign pkt_ready = !rst && (state_q == S_IDLE);
  assign busy      = !rst && (state_q != S_IDLE);
  assign pkt_sent  = !rst && sent_q;

endmodule

// File: tb/tb_ni_inject.sv
module tb_ni_inject;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  pkt_dst_x, pkt_dst_y, pkt_dst_z;
  logic [3:0]  pkt_len;
  logic        dat_valid;
  logic        dat_ready;
  logic [37:0] dat_in;
  logic [39:0] flit_out;
  logic        req_out;
  logic        grnt_in;
  logic        busy;
  logic        pkt_sent;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  bit          sent_q[$];

  ni_inject dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_dst_x (pkt_dst_x),
    .pkt_dst_y (pkt_dst_y),
    .pkt_dst_z (pkt_dst_z),
    .pkt_len   (pkt_len),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .dat_in    (dat_in),
    .flit_out  (flit_out),
    .req_out   (req_out),
    .grnt_in   (grnt_in),
    .busy      (busy),
    .pkt_sent  (pkt_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [37:0] w);
    dat_valid = 1'b1;
    dat_in    = w;
    step();
    dat_valid = 1'b0;
  endtask

  task automatic send_desc(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                           input logic [3:0] len);
    pkt_dst_x = x;
    pkt_dst_y = y;
    pkt_dst_z = z;
    pkt_len   = len;
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  // Monitor: every granted flit is popped against the scoreboard
  always @(negedge clk) begin
    if (req_out && grnt_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %h expected none at %0t", flit_out, $time);
      end else begin
        check("flit", {24'd0, flit_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (!req_out) check("idle_flit_zero", {24'd0, flit_out}, 64'd0);
    if (pkt_sent) begin
      if (sent_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt_sent: got 1 expected 0 at %0t", $time);
      end else begin
        checks++;
        void'(sent_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pkt_valid = 0; dat_valid = 0; grnt_in = 0; dat_in = '0;
    pkt_dst_x = 0; pkt_dst_y = 0; pkt_dst_z = 0; pkt_len = 0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'($urandom); dat_valid = 1'($urandom); grnt_in = 1'($urandom);
      dat_in = {6'($urandom), 32'($urandom)};
      pkt_dst_x = 3'($urandom); pkt_len = 4'($urandom);
      @(negedge clk);
      check("rst_req",  {63'd0, req_out}, 64'd0);
      check("rst_flit", {24'd0, flit_out}, 64'd0);
      check("rst_pkt_ready", {63'd0, pkt_ready}, 64'd0);
      check("rst_dat_ready", {63'd0, dat_ready}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_pkt_sent", {63'd0, pkt_sent}, 64'd0);
      step();
    end
    rst = 0; pkt_valid = 0; dat_valid = 0; grnt_in = 0; pkt_len = 0; pkt_dst_x = 0;
    @(negedge clk);
    check("post_rst_pkt_ready", {63'd0, pkt_ready}, 64'd1);
    check("post_rst_dat_ready", {63'd0, dat_ready}, 64'd1);
    step();

    // Basic packet, prefilled payload, grant tied high
    push_word(38'hA); push_word(38'hB); push_word(38'hC);
    exp_q.push_back(40'hD1_0003_0000);
    exp_q.push_back(40'h80_0000_000A);
    exp_q.push_back(40'h80_0000_000B);
    exp_q.push_back(40'h40_0000_000C);
    sent_q.push_back(1'b1);
    grnt_in = 1'b1;
    send_desc(3'd2, 3'd1, 3'd0, 4'd3);
    @(negedge clk);
    check("hdr_latency_req", {63'd0, req_out}, 64'd1);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("basic_pkt_sent", {63'd0, pkt_sent}, 64'd1);
    check("basic_idle", {63'd0, busy}, 64'd0);
    step();

    // Grant stall on the second body flit
    push_word(38'h11); push_word(38'h22); push_word(38'h33);
    exp_q.push_back(40'hCA_6003_0000);
    exp_q.push_back(40'h80_0000_0011);
    exp_q.push_back(40'h80_0000_0022);
    exp_q.push_back(40'h40_0000_0033);
    sent_q.push_back(1'b1);
    grnt_in = 1'b1;
    send_desc(3'd1, 3'd2, 3'd3, 4'd3);
    step();
    step();
    grnt_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", {63'd0, req_out}, 64'd1);
      check("stall_flit", {24'd0, flit_out}, 64'h80_0000_0022);
      step();
    end
    grnt_in = 1'b1;
    wait_idle("stall_done");
    step();

    // Starvation: payload arrives 4 cycles after header grant
    exp_q.push_back(40'hD8_2002_0000);
    exp_q.push_back(40'h92_3456_789A);
    exp_q.push_back(40'h40_0000_0055);
    sent_q.push_back(1'b1);
    grnt_in = 1'b1;
    send_desc(3'd3, 3'd0, 3'd1, 4'd2);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("starve_req", {63'd0, req_out}, 64'd0);
      check("starve_busy", {63'd0, busy}, 64'd1);
      step();
    end
    push_word(38'h12_3456_789A);
    push_word(38'h00_0000_0055);
    wait_idle("starve_done");
    step();

    // Zero length packet
    exp_q.push_back(40'hFF_E000_0000);
    exp_q.push_back(40'h40_0000_0000);
    sent_q.push_back(1'b1);
    grnt_in = 1'b1;
    send_desc(3'd7, 3'd7, 3'd7, 4'd0);
    wait_idle("zero_len_done");
    step();

    // Backpressure: fill FIFO with no packet pending
    grnt_in = 1'b0;
    for (int i = 1; i <= 7; i++) push_word(38'(i));
    @(negedge clk);
    check("fifo_7_ready", {63'd0, dat_ready}, 64'd1);
    step();
    push_word(38'd8);
    @(negedge clk);
    check("fifo_full_ready", {63'd0, dat_ready}, 64'd0);
    step();

    // len-8 packet aborted by reset after 3 flits
    exp_q.push_back(40'hC0_2008_0000);
    exp_q.push_back(40'h80_0000_0001);
    exp_q.push_back(40'h80_0000_0002);
    grnt_in = 1'b1;
    send_desc(3'd0, 3'd0, 3'd1, 4'd8);
    step(); step(); step();
    rst = 1'b1;
    grnt_in = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_pkt_ready", {63'd0, pkt_ready}, 64'd1);
    check("abort_dat_ready", {63'd0, dat_ready}, 64'd1);
    check("abort_req", {63'd0, req_out}, 64'd0);
    step();

    // FIFO must be empty after reset: len-1 packet starves until new data
    exp_q.push_back(40'hC0_0001_0000);
    grnt_in = 1'b1;
    send_desc(3'd0, 3'd0, 3'd0, 4'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("flushed_req", {63'd0, req_out}, 64'd0);
      step();
    end
    exp_q.push_back(40'h40_0000_005A);
    sent_q.push_back(1'b1);
    push_word(38'h5A);
    wait_idle("flushed_done");
    step(); step();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("sent_q_drained", 64'(sent_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
